// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed hex driver for a common-anode 7-segment display.
// Define SEG_LZB_EN to blank leading zero digits above digit 0.
module seg_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic [DIGITS-1:0]     den,
    output logic [7:0]            dout
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [4*DIGITS-1:0] dbuf;
    logic [DIGITS-1:0]   dpbuf;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                wrap;
    logic                blank;
    logic                hide;
    logic [3:0]          nib;
    always_comb begin
        wrap  = presc == PW'(SCAN_DIV - 1);
        blank = int'(presc) < BLANK_CYC;
        nib   = dbuf[{idx, 2'b00} +: 4];
    end
`ifdef SEG_LZB_EN
    // A digit hides when it and everything above it is zero; digit 0 always shows.
    logic [DIGITS-1:0] lz;
    assign lz[0] = 1'b0;
    for (genvar k = 1; k < DIGITS; k++) begin : g_lz
        assign lz[k] = ~|dbuf[4*DIGITS-1:4*k] & ~dpbuf[k];
    end
    assign hide = lz[idx];
`else
    assign hide = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            dbuf  <= '0;
            dpbuf <= '0;
            presc <= '0;
            idx   <= '0;
            den   <= '1;
            dout  <= 8'hFF;
        end else begin
            if (load) begin
                dbuf  <= din;
                dpbuf <= dp;
            end
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            den  <= blank ? '1 : ~(DIGITS'(1) << idx);
            dout <= blank || hide ? 8'hFF : {~dpbuf[idx], SEG_TBL[nib]};
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench; a time-based display model predicts den/dout per edge.
module tb_seg_scan_driver;
    localparam int DIGITS = 4;
    localparam int SD     = 4;
    localparam int BC     = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  den;
    logic [7:0]  dout;

    seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .reset(reset), .din(din), .dp(dp), .load(load), .den(den), .dout(dout)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [3:0]  mbuf [DIGITS];
    logic [3:0]  mdp;
    int          cyc;
    logic [11:0] q [$];
    int          errors = 0;
    int          checks = 0;

    // Model: cycles since reset give slot position and digit; buffer is a nibble array.
    task automatic step(input logic r, input logic l, input logic [15:0] d, input logic [3:0] p);
        logic [3:0] e_den;
        logic [7:0] e_dout;
        logic       hide;
        int         pr;
        int         ix;
        reset = r; load = l; din = d; dp = p;
        e_den = 4'hF;
        e_dout = 8'hFF;
        if (r) begin
            cyc = 0;
            mdp = '0;
            for (int j = 0; j < DIGITS; j++) mbuf[j] = '0;
        end else begin
            pr = cyc % SD;
            ix = (cyc / SD) % DIGITS;
            if (pr >= BC) begin
                hide = 1'b0;
`ifdef SEG_LZB_EN
                hide = ix > 0 && !mdp[ix];
                for (int j = ix; j < DIGITS; j++) if (mbuf[j] != 0) hide = 1'b0;
`endif
                e_den  = ~(4'b0001 << ix);
                e_dout = hide ? 8'hFF : {~mdp[ix], seg_tbl[mbuf[ix]]};
            end
            if (l) begin
                for (int j = 0; j < DIGITS; j++) mbuf[j] = d[4*j +: 4];
                mdp = p;
            end
            cyc++;
        end
        q.push_back({e_den, e_dout});
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
    endtask

    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks += 3;
            if (den !== e[11:8]) begin
                errors++;
                $display("FAIL den: got %h want %h at %0t", den, e[11:8], $time);
            end
            if (dout !== e[7:0]) begin
                errors++;
                $display("FAIL dout: got %h want %h at %0t", dout, e[7:0], $time);
            end
            if ($countones(~den) > 1) begin
                errors++;
                $display("FAIL onehot: den %b has %0d low bits, allowed 1", den, $countones(~den));
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        idle(5);
        step(1'b0, 1'b1, 16'h1234, 4'b0001);
        idle(6);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h5555, 4'hF);
        step(1'b0, 1'b1, 16'h1234, 4'b0001);
        idle(20);
        while (cyc % (SD * DIGITS) != SD * DIGITS - 1) idle(1);
        step(1'b0, 1'b1, 16'hABCD, 4'b0000);
        idle(20);
        for (int v = 0; v < 16; v++) begin
            step(1'b0, 1'b1, {12'h000, 4'(v)}, 4'b0000);
            idle(16);
        end
        step(1'b0, 1'b1, 16'h0050, 4'b0000);
        idle(17);
        for (int i = 0; i < 1000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom);
        step(1'b0, 1'b0, '0, '0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
